// File: rtl/crack_pkg.sv
// Shared types and widths for the crack result collector.
package crack_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    SEARCH = 2'd2,
    COPY   = 2'd3
  } state_t;

  localparam int KEY_W = 24;
  localparam int PT_AW = 8;
  localparam int PT_DW = 8;

endpackage

// File: rtl/crack_prio_pick.sv
// Lowest-index priority picker: request vector -> one-hot grant, binary index, any.
module crack_prio_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
      end
    end
  end

endmodule

// File: rtl/crack_collector.sv
// Result stage for NCORES crack cores: starts them, picks the first hit, copies its plaintext.
// Optional SEARCH timeout is compiled in with CRACK_TIMEOUT_EN.
module crack_collector
  import crack_pkg::*;
#(
  parameter  int NCORES         = 4,
  parameter  int TIMEOUT_CYCLES = 2**26,
  localparam int WIDX           = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  output logic                      rdy,
  output logic                      done,
  output logic [KEY_W-1:0]          key,
  output logic                      key_valid,
  output logic [WIDX-1:0]           winner,
  output logic [NCORES-1:0]         core_en,
  input  logic [NCORES-1:0]         core_rdy,
  output logic [NCORES-1:0]         core_halt,
  input  logic [NCORES-1:0]         core_key_valid,
  input  logic [NCORES*KEY_W-1:0]   core_key,
  input  logic [NCORES*PT_AW-1:0]   core_pt_addr,
  input  logic [NCORES*PT_DW-1:0]   core_pt_wrdata,
  input  logic [NCORES-1:0]         core_eof,
  output logic [PT_AW-1:0]          pt_addr,
  output logic [PT_DW-1:0]          pt_wrdata,
  output logic                      pt_wren,
  output logic [1:0]                state_dbg
);

  state_t              state, state_nxt;
  logic [NCORES-1:0]   pick_onehot;
  logic [WIDX-1:0]     pick_idx;
  logic                hit;
  logic [WIDX-1:0]     sel;
  logic                sel_valid;
  logic                sel_eof;
  logic [PT_AW-1:0]    sel_addr;
  logic [PT_DW-1:0]    sel_data;
  logic [KEY_W-1:0]    sel_key;
  logic                timeout_hit;

  crack_prio_pick #(.N(NCORES), .IW(WIDX)) u_pick (
    .req    (core_key_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (hit)
  );

  // In the hit cycle the winner is not registered yet, so steer by the live pick.
  assign sel       = (state == SEARCH) ? pick_idx : winner;
  assign sel_valid = core_key_valid[sel];
  assign sel_eof   = core_eof[sel];
  assign sel_addr  = core_pt_addr[PT_AW*sel +: PT_AW];
  assign sel_data  = core_pt_wrdata[PT_DW*sel +: PT_DW];
  assign sel_key   = core_key[KEY_W*sel +: KEY_W];

`ifdef CRACK_TIMEOUT_EN
  logic [31:0] search_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != SEARCH) search_cnt <= '0;
    else                        search_cnt <= search_cnt + 32'd1;
  end

  assign timeout_hit = (state == SEARCH) && !hit && (search_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = ARM;
      ARM:     if (&core_rdy) state_nxt = SEARCH;
      SEARCH: begin
        if (hit)              state_nxt = COPY;
        else if (timeout_hit) state_nxt = IDLE;
      end
      COPY:    if (sel_eof) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    core_en   = '0;
    core_halt = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    if (rst) begin
      core_halt = '1;
    end else begin
      case (state)
        ARM: if (&core_rdy) core_en = '1;
        SEARCH: begin
          if (hit) begin
            core_halt = ~pick_onehot;
            pt_addr   = sel_addr;
            pt_wrdata = sel_data;
            pt_wren   = sel_valid & ~sel_eof;
          end else if (timeout_hit) begin
            core_halt = '1;
          end
        end
        COPY: begin
          pt_addr   = sel_addr;
          pt_wrdata = sel_data;
          pt_wren   = sel_valid & ~sel_eof;
        end
        default: ;
      endcase
    end
  end

  assign rdy       = (state == IDLE);
  assign state_dbg = state;

  // done is registered, so it lands one cycle after eof (or the timeout cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      key       <= '0;
      key_valid <= 1'b0;
      winner    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (en) key_valid <= 1'b0;
        SEARCH: begin
          if (hit) begin
            winner <= pick_idx;
            key    <= sel_key;
          end else if (timeout_hit) begin
            done <= 1'b1;
          end
        end
        COPY: begin
          if (sel_eof) begin
            key_valid <= 1'b1;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
